// File: rtl/bus_timer.sv
// Memory-mapped timer with compare match, auto-reload and a level interrupt.
// Define BUS_TIMER_PRESCALE_EN to add the 16-bit PRESCALE register and its counter.
module bus_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          CNT_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_data_i,
  input  logic        bus_write,
  output logic [31:0] bus_data_o,
  output logic        irq
);

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_COUNT    = 3'd1;
  localparam logic [2:0] REG_COMPARE  = 3'd2;
  localparam logic [2:0] REG_STATUS   = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;

  logic [31:0]      offset;
  logic             hit;
  logic [2:0]       idx;
  logic             wr_ctrl, wr_count, wr_compare, wr_status;

  logic [2:0]       ctrl;
  logic             en, autoreload, irqen;
  logic [CNT_W-1:0] count, compare;
  logic             match;
  logic             tick;
  logic             match_now;
  logic [15:0]      prescale_rd;

  // Unsigned wrap-around makes addresses below BASE_ADDR land far above 4.
  assign offset = bus_addr - BASE_ADDR;
  assign hit    = (offset < 32'd5);
  assign idx    = offset[2:0];

  assign wr_ctrl    = bus_write && hit && (idx == REG_CTRL);
  assign wr_count   = bus_write && hit && (idx == REG_COUNT);
  assign wr_compare = bus_write && hit && (idx == REG_COMPARE);
  assign wr_status  = bus_write && hit && (idx == REG_STATUS);

  assign en         = ctrl[0];
  assign autoreload = ctrl[1];
  assign irqen      = ctrl[2];
  assign match_now  = (count == compare);

`ifdef BUS_TIMER_PRESCALE_EN
  logic        wr_prescale;
  logic [15:0] prescale, pcnt;
  logic        pcnt_hit;

  assign wr_prescale = bus_write && hit && (idx == REG_PRESCALE);
  assign pcnt_hit    = (pcnt == prescale);
  assign tick        = en && pcnt_hit;
  assign prescale_rd = prescale;

  // PCNT is held at zero while disabled so enabling always starts a full period.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= '0;
      pcnt     <= '0;
    end else begin
      if (wr_prescale)
        prescale <= bus_data_i[15:0];
      if (!en || pcnt_hit)
        pcnt <= '0;
      else
        pcnt <= pcnt + 16'd1;
    end
  end
`else
  assign tick        = en;
  assign prescale_rd = 16'd0;
`endif

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl    <= '0;
      count   <= '0;
      compare <= '0;
      match   <= 1'b0;
    end else begin
      if (wr_ctrl)
        ctrl <= bus_data_i[2:0];
      if (wr_compare)
        compare <= bus_data_i[CNT_W-1:0];

      // A core write to COUNT overrides the tick update in the same cycle.
      if (wr_count)
        count <= bus_data_i[CNT_W-1:0];
      else if (tick)
        count <= (match_now && autoreload) ? '0 : count + CNT_W'(1);

      // Setting MATCH wins over a coincident write-1-to-clear.
      if (tick && match_now)
        match <= 1'b1;
      else if (wr_status && bus_data_i[0])
        match <= 1'b0;
    end
  end

  assign irq = match && irqen;

  // NOTE: the default assignment keeps this combinational block latch-free.
  always_comb begin
    bus_data_o = 32'd0;
    if (hit) begin
      case (idx)
        REG_CTRL:     bus_data_o = 32'(ctrl);
        REG_COUNT:    bus_data_o = 32'(count);
        REG_COMPARE:  bus_data_o = 32'(compare);
        REG_STATUS:   bus_data_o = 32'(match);
        REG_PRESCALE: bus_data_o = 32'(prescale_rd);
        default:      bus_data_o = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer; adapts its expectations to
// whether BUS_TIMER_PRESCALE_EN is defined for the build.
module tb_bus_timer;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] OFF_CTRL     = 32'd0;
  localparam logic [31:0] OFF_COUNT    = 32'd1;
  localparam logic [31:0] OFF_COMPARE  = 32'd2;
  localparam logic [31:0] OFF_STATUS   = 32'd3;
  localparam logic [31:0] OFF_PRESCALE = 32'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] bus_addr = 32'd0;
  logic [31:0] bus_data_i = 32'd0;
  logic        bus_write = 1'b0;
  logic [31:0] bus_data_o;
  logic        irq;

  int errors = 0;
  int checks = 0;

  bus_timer #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_addr   (bus_addr),
    .bus_data_i (bus_data_i),
    .bus_write  (bus_write),
    .bus_data_o (bus_data_o),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Write commits on the next rising edge; returns 1 ns after that edge.
  task automatic wr(input logic [31:0] off, input logic [31:0] data);
    @(negedge clk);
    bus_addr   = BASE + off;
    bus_data_i = data;
    bus_write  = 1'b1;
    @(posedge clk);
    #1;
    bus_write  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] val);
    bus_addr = BASE + off;
    #1;
    val = bus_data_o;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rd(i, v);
      checks++;
      if (v !== 32'd0) begin
        errors++;
        $display("FAIL reset_read_off%0d: got %h expected %h", i, v, 32'd0);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
  endtask

  task automatic test_match_autoreload;
    logic [31:0] v;
    wr(OFF_COMPARE, 32'd3);
    wr(OFF_PRESCALE, 32'd0);
    wr(OFF_CTRL, 32'h7);
    repeat (3) @(posedge clk);
    #1;
    rd(OFF_COUNT, v);
    checks++;
    if (v !== 32'd3) begin errors++; $display("FAIL count_before_match: got %h expected %h", v, 32'd3); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_before_match: got %b expected 0", irq); end
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_at_match: got %b expected 1", irq); end
    rd(OFF_STATUS, v);
    checks++;
    if (v !== 32'd1) begin errors++; $display("FAIL status_at_match: got %h expected %h", v, 32'd1); end
    rd(OFF_COUNT, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL count_autoreload: got %h expected %h", v, 32'd0); end
    wr(OFF_STATUS, 32'd0);
    rd(OFF_STATUS, v);
    checks++;
    if (v !== 32'd1) begin errors++; $display("FAIL status_write0_noeffect: got %h expected %h", v, 32'd1); end
    wr(OFF_CTRL, 32'd0);
    wr(OFF_STATUS, 32'd1);
    rd(OFF_STATUS, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL status_w1c: got %h expected %h", v, 32'd0); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_w1c: got %b expected 0", irq); end
    repeat (3) @(posedge clk);
    #1;
    rd(OFF_COUNT, v);
    checks++;
    if (v !== 32'd2) begin errors++; $display("FAIL count_held_disabled: got %h expected %h", v, 32'd2); end
  endtask

  task automatic test_prescale;
    logic [31:0] v;
`ifdef BUS_TIMER_PRESCALE_EN
    wr(OFF_PRESCALE, 32'd4);
    rd(OFF_PRESCALE, v);
    checks++;
    if (v !== 32'd4) begin errors++; $display("FAIL prescale_readback: got %h expected %h", v, 32'd4); end
    wr(OFF_COMPARE, 32'hFFFF_FFFF);
    wr(OFF_COUNT, 32'd0);
    wr(OFF_CTRL, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    rd(OFF_COUNT, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL prescale_before_tick: got %h expected %h", v, 32'd0); end
    @(posedge clk);
    #1;
    rd(OFF_COUNT, v);
    checks++;
    if (v !== 32'd1) begin errors++; $display("FAIL prescale_first_tick: got %h expected %h", v, 32'd1); end
    repeat (4) @(posedge clk);
    #1;
    rd(OFF_COUNT, v);
    checks++;
    if (v !== 32'd1) begin errors++; $display("FAIL prescale_hold: got %h expected %h", v, 32'd1); end
    @(posedge clk);
    #1;
    rd(OFF_COUNT, v);
    checks++;
    if (v !== 32'd2) begin errors++; $display("FAIL prescale_second_tick: got %h expected %h", v, 32'd2); end
    wr(OFF_CTRL, 32'd0);
    wr(OFF_COUNT, 32'hFFFF_FFFE);
    wr(OFF_CTRL, 32'h1);
    repeat (5) @(posedge clk);
`else
    wr(OFF_PRESCALE, 32'd9);
    rd(OFF_PRESCALE, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL prescale_absent_reads0: got %h expected %h", v, 32'd0); end
    wr(OFF_COMPARE, 32'hFFFF_FFFF);
    wr(OFF_COUNT, 32'd0);
    wr(OFF_CTRL, 32'h1);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      rd(OFF_COUNT, v);
      checks++;
      if (v !== 32'(i)) begin errors++; $display("FAIL every_cycle_tick%0d: got %h expected %h", i, v, 32'(i)); end
    end
    wr(OFF_CTRL, 32'd0);
    wr(OFF_COUNT, 32'hFFFF_FFFE);
    wr(OFF_CTRL, 32'h1);
    @(posedge clk);
`endif
    #1;
    rd(OFF_COUNT, v);
    checks++;
    if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL count_all_ones: got %h expected %h", v, 32'hFFFF_FFFF); end
    rd(OFF_STATUS, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL status_before_wrap: got %h expected %h", v, 32'd0); end
`ifdef BUS_TIMER_PRESCALE_EN
    repeat (5) @(posedge clk);
`else
    @(posedge clk);
`endif
    #1;
    rd(OFF_STATUS, v);
    checks++;
    if (v !== 32'd1) begin errors++; $display("FAIL status_at_wrap: got %h expected %h", v, 32'd1); end
    rd(OFF_COUNT, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL count_wrapped: got %h expected %h", v, 32'd0); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b expected 0", irq); end
    wr(OFF_CTRL, 32'd0);
    wr(OFF_STATUS, 32'd1);
  endtask

  task automatic test_priority;
    logic [31:0] v;
    wr(OFF_PRESCALE, 32'd0);
    wr(OFF_COMPARE, 32'h0000_FFFF);
    wr(OFF_COUNT, 32'd0);
    wr(OFF_CTRL, 32'h1);
    wr(OFF_COUNT, 32'h100);
    rd(OFF_COUNT, v);
    checks++;
    if (v !== 32'h100) begin errors++; $display("FAIL count_write_priority: got %h expected %h", v, 32'h100); end
    @(posedge clk);
    #1;
    rd(OFF_COUNT, v);
    checks++;
    if (v !== 32'h101) begin errors++; $display("FAIL count_after_write_tick: got %h expected %h", v, 32'h101); end
    wr(OFF_CTRL, 32'd0);
    rd(OFF_STATUS, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL status_pre_coincident: got %h expected %h", v, 32'd0); end
    wr(OFF_COUNT, 32'd5);
    wr(OFF_COMPARE, 32'd5);
    wr(OFF_CTRL, 32'h1);
    wr(OFF_STATUS, 32'd1);
    rd(OFF_STATUS, v);
    checks++;
    if (v !== 32'd1) begin errors++; $display("FAIL match_beats_w1c: got %h expected %h", v, 32'd1); end
    rd(OFF_COUNT, v);
    checks++;
    if (v !== 32'd6) begin errors++; $display("FAIL count_no_autoreload: got %h expected %h", v, 32'd6); end
    wr(OFF_CTRL, 32'd0);
    wr(OFF_STATUS, 32'd1);
    rd(OFF_STATUS, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL w1c_after_disable: got %h expected %h", v, 32'd0); end
  endtask

  task automatic test_reset_mid_count;
    logic [31:0] v;
    wr(OFF_PRESCALE, 32'd2);
    wr(OFF_COMPARE, 32'h50);
    wr(OFF_COUNT, 32'h50);
    wr(OFF_CTRL, 32'h7);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_before_reset: got %b expected 1", irq); end
    @(negedge clk);
    reset      = 1'b1;
    bus_addr   = BASE + OFF_COMPARE;
    bus_data_i = 32'h1234;
    bus_write  = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    bus_write = 1'b0;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_reset: got %b expected 0", irq); end
    for (int i = 0; i < 5; i++) begin
      rd(i, v);
      checks++;
      if (v !== 32'd0) begin
        errors++;
        $display("FAIL midreset_read_off%0d: got %h expected %h", i, v, 32'd0);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    rd(OFF_COUNT, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL count_idle_after_reset: got %h expected %h", v, 32'd0); end
  endtask

  initial begin
    test_reset();
    test_match_autoreload();
    test_prescale();
    test_priority();
    test_reset_mid_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hFFFF_0000, word address of register 0.
REQ-002 SHALL have parameter CNT_W, default 32, width of COUNT and COMPARE (legal values 16..32).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port bus_addr, input, 32, word address driven by the core.
REQ-006 SHALL have port bus_data_i, input, 32, write data driven by the core.
REQ-007 SHALL have port bus_write, input, 1, write strobe driven by the core.
REQ-008 SHALL have port bus_data_o, output, 32, read data returned to the core.
REQ-009 SHALL have port irq, output, 1, level interrupt request.

Function
REQ-010 SHALL decode a hit when bus_addr is in BASE_ADDR..BASE_ADDR+4; reg index = bus_addr - BASE_ADDR.
REQ-011 SHALL map registers: 0 CTRL (bit0 EN, bit1 AUTORELOAD, bit2 IRQEN), 1 COUNT, 2 COMPARE, 3 STATUS (bit0 MATCH), 4 PRESCALE (bits15:0).
REQ-012 SHALL drive bus_data_o combinationally from bus_addr in the same cycle, zero-extended; 0 on miss or on unused bits.
REQ-013 SHALL perform a write on the rising edge when bus_write=1 and the address hits; reads have no side effects.
REQ-014 SHALL ignore writes on a miss; no register changes.
REQ-015 SHALL keep a 16-bit prescale counter PCNT that counts only while EN=1; tick when PCNT==PRESCALE, PCNT then returns to 0.
REQ-016 SHALL clear PCNT on any cycle with EN=0, so the first tick after enabling comes PRESCALE+1 cycles later.
REQ-017 SHALL on a tick with COUNT==COMPARE set MATCH, and load COUNT with 0 if AUTORELOAD=1, else COUNT+1.
REQ-018 SHALL on a tick with COUNT!=COMPARE load COUNT with COUNT+1 modulo 2^CNT_W (all-ones wraps to 0 without setting MATCH unless COMPARE matches).
REQ-019 SHALL give a core write to COUNT priority over the tick update in the same cycle; PCNT still advances.
REQ-020 SHALL clear MATCH on a STATUS write with bus_data_i[0]=1 (write-1-to-clear); writing 0 has no effect.
REQ-021 SHALL give a MATCH set priority over a simultaneous W1C clear.
REQ-022 SHALL drive irq = MATCH & IRQEN combinationally from registered state.
REQ-023 SHALL take effect of a CTRL write from the next cycle; COUNT, COMPARE and MATCH are held when EN=0.

Reset
REQ-024 SHALL on reset=1 at a rising edge clear CTRL, COUNT, COMPARE, STATUS, PRESCALE and PCNT to 0.
REQ-025 SHALL give reset priority over any simultaneous bus write or tick; irq=0 from the cycle after reset.
REQ-026 SHALL keep bus_data_o a pure function of state and bus_addr during reset (reads 0 after the reset edge).

Configuration
REQ-027 SHALL honour macro BUS_TIMER_PRESCALE_EN: when defined, PRESCALE and PCNT exist as in REQ-015/016.
REQ-028 SHALL, without BUS_TIMER_PRESCALE_EN, tick every cycle with EN=1, read PRESCALE as 0 and ignore its writes.

Verification
REQ-029 SHALL cover: reset, then read all 5 regs and BASE_ADDR+5 -> all 0, irq=0.
REQ-030 SHALL cover: COMPARE=3, PRESCALE=0, CTRL=0x7 -> MATCH and irq high 4 ticks after enable, COUNT reads 0 next cycle.
REQ-031 SHALL cover: PRESCALE=4, COMPARE=0xFFFF_FFFF, CTRL=0x1 -> COUNT increments every 5 cycles; preset COUNT=0xFFFF_FFFE reaches MATCH then wraps to 0.
REQ-032 SHALL cover: write COUNT=0x100 on a tick cycle -> COUNT reads 0x100, not 0x101; STATUS W1C coincident with match -> MATCH stays 1.
REQ-033 SHALL cover: assert reset mid-count with bus_write=1 to COMPARE -> all regs 0, write discarded.
REQ-034 SHALL cover: build without BUS_TIMER_PRESCALE_EN, write PRESCALE=9 -> reads 0, COUNT increments every enabled cycle.
